// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its next-PC logic.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_TIMEOUT  = 15;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump, jump-register.
// ADDR_W must exceed 26 so the jump keeps at least one upper PC bit.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sel,
    input  logic              zero,
    input  logic [15:0]       br_off,
    input  logic [25:0]       j_target,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] p1;
    logic [ADDR_W-1:0] br_ext;

    assign p1     = pc + ADDR_W'(1);
    assign br_ext = {{(ADDR_W-16){br_off[15]}}, br_off};

    always_comb begin
        next_pc = p1;
        case (pc_sel)
            PC_SEQ:  next_pc = p1;
            PC_BR:   next_pc = zero ? (p1 + br_ext) : p1;
            // Jump keeps the region bits of the incremented PC, not of the current one.
            PC_J:    next_pc = {p1[ADDR_W-1:26], j_target};
            PC_JR:   next_pc = jr_addr;
            default: next_pc = p1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue/PC-update controller: owns the PC, runs the instruction-memory
// handshake and holds each fetched word until the datapath retires it.
//
// state  | meaning
// FETCH  | start a request for pc; imem_req rises on the next edge
// WAIT   | imem_req high, waiting for imem_ack or the fetch timeout
// ISSUE  | instr_valid high, waiting for exec_done to retire and step pc
// HALTED | pc frozen; resume restarts fetching unless fetch_err is set
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic [1:0]        pc_sel,
    input  logic              zero,
    input  logic [15:0]       br_off,
    input  logic [25:0]       j_target,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err,
    output logic [31:0]       retired
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              take_ack;
    logic              tmo_hit;
    logic              retire;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc       (pc),
        .pc_sel   (pc_sel),
        .zero     (zero),
        .br_off   (br_off),
        .j_target (j_target),
        .jr_addr  (jr_addr),
        .next_pc  (pc_nxt)
    );

    // An ack on the last allowed WAIT cycle still wins over the timeout.
    assign take_ack = (state == ST_WAIT) && imem_ack;
    assign tmo_hit  = (state == ST_WAIT) && !imem_ack && (tmo_cnt == TMO_LAST);
    assign retire   = (state == ST_ISSUE) && exec_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (take_ack) begin
                    state_nxt = ST_ISSUE;
                end else if (tmo_hit) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_ISSUE: begin
                if (retire) begin
                    state_nxt = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (resume && !fetch_err) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            tmo_cnt     <= '0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            retired     <= 32'h0;
        end else begin
            if (state == ST_FETCH) begin
                imem_req <= 1'b1;
                tmo_cnt  <= '0;
            end else if (state == ST_WAIT && !imem_ack) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (take_ack || tmo_hit) begin
                imem_req <= 1'b0;
            end

            if (take_ack) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end

            if (tmo_hit) begin
                fetch_err <= 1'b1;
            end

            if (retire) begin
                instr_valid <= 1'b0;
                retired     <= retired + 32'd1;
                pc          <= pc_nxt;
            end
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: stimulus queues expected fetch addresses
// and instruction words, a monitor pops and compares them as the DUT presents them.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  pc_sel;
    logic        zero;
    logic [15:0] br_off;
    logic [25:0] j_target;
    logic [31:0] jr_addr;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic        halted;
    logic        fetch_err;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_retired = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];

    typedef struct {
        logic [1:0]  sel;
        logic        z;
        logic [15:0] off;
        logic [25:0] tgt;
        logic [31:0] jr;
        int          delay;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    fetch_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .TIMEOUT  (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc_sel      (pc_sel),
        .zero        (zero),
        .br_off      (br_off),
        .j_target    (j_target),
        .jr_addr     (jr_addr),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        pc_sel     = PC_SEQ;
        zero       = 1'b0;
        br_off     = 16'h0;
        j_target   = 26'h0;
        jr_addr    = 32'h0;
        halt       = 1'b0;
        resume     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"},    imem_req,    0);
        check({tag, "_imem_addr"},   imem_addr,   32'h0);
        check({tag, "_pc"},          pc,          32'h0);
        check({tag, "_instr"},       instr,       32'h0);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_halted"},      halted,      0);
        check({tag, "_fetch_err"},   fetch_err,   0);
        check({tag, "_retired"},     retired,     32'h0);
    endtask

    // Entered on a negedge; returns on the negedge after the retiring edge.
    task automatic run_instr(input logic [31:0] word, input int ack_delay,
                             input logic [1:0] sel, input logic z, input logic [15:0] off,
                             input logic [25:0] tgt, input logic [31:0] jr,
                             input logic hlt, input logic rsm, input logic [31:0] exp_pc,
                             output int req_lat);
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clock);
            n++;
        end
        req_lat = n;
        check("req_seen", imem_req, 1);
        if (!imem_req) return;
        repeat (ack_delay) @(negedge clock);
        instr_q.push_back(word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b1;
        pc_sel     = sel;
        zero       = z;
        br_off     = off;
        j_target   = tgt;
        jr_addr    = jr;
        halt       = hlt;
        resume     = rsm;
        addr_q.push_back(exp_pc);
        exp_retired++;
        @(negedge clock);
        idle_inputs();
        check("pc_after_retire", pc, exp_pc);
        check("instr_valid_cleared", instr_valid, 0);
    endtask

    initial begin : monitor
        logic        prev_req;
        logic        prev_valid;
        logic [31:0] exp;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    n_checks++;
                    if (addr_q.size() == 0) begin
                        $display("FAIL fetch_addr: request at 0x%08h, none expected", imem_addr);
                    end else begin
                        exp = addr_q.pop_front();
                        if (imem_addr !== exp)
                            $display("FAIL fetch_addr: got 0x%08h, expected 0x%08h", imem_addr, exp);
                        else
                            n_pass++;
                    end
                end
                if (instr_valid && !prev_valid) begin
                    n_checks++;
                    if (instr_q.size() == 0) begin
                        $display("FAIL instr: valid word 0x%08h, none expected", instr);
                    end else begin
                        exp = instr_q.pop_front();
                        if (instr !== exp)
                            $display("FAIL instr: got 0x%08h, expected 0x%08h", instr, exp);
                        else
                            n_pass++;
                    end
                end
                prev_req   = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    initial begin : stimulus
        int lat;
        int n;
        logic frozen_ok;

        vecs[0]  = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'd10,         0, 32'd10};
        vecs[1]  = '{PC_BR,  1'b1, 16'hFFFC, 26'h0,       32'h0,          2, 32'd7};
        vecs[2]  = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'd10,         0, 32'd10};
        vecs[3]  = '{PC_BR,  1'b0, 16'hFFFC, 26'h0,       32'h0,          1, 32'd11};
        vecs[4]  = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'h0400_0005,  0, 32'h0400_0005};
        vecs[5]  = '{PC_J,   1'b0, 16'h0000, 26'h123,     32'h0,          0, 32'h0400_0123};
        vecs[6]  = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'hDEAD_BEEF,  0, 32'hDEAD_BEEF};
        vecs[7]  = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'hFFFF_FFFF,  0, 32'hFFFF_FFFF};
        vecs[8]  = '{PC_SEQ, 1'b0, 16'h0000, 26'h0,       32'h0,          0, 32'h0};
        vecs[9]  = '{PC_BR,  1'b1, 16'h0005, 26'h0,       32'h0,          0, 32'd6};
        vecs[10] = '{PC_JR,  1'b0, 16'h0000, 26'h0,       32'h07FF_FFFF,  0, 32'h07FF_FFFF};
        vecs[11] = '{PC_J,   1'b0, 16'h0000, 26'h3FF_FFFF, 32'h0,         0, 32'h0BFF_FFFF};

        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        check_reset_values("por");
        addr_q.push_back(32'h0);
        #2 reset = 1'b1;
        @(negedge clock);

        // Sequential stepping: one instruction every 3 cycles
        for (int i = 0; i < 4; i++) begin
            run_instr(32'h1000_0000 + 32'(i), 0, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                      1'b0, 1'b0, 32'(i + 1), lat);
            if (i > 0) check("fetch_period", lat, 1);
        end
        check("retired_seq", retired, exp_retired);

        for (int i = 0; i < 12; i++) begin
            run_instr(32'hC0DE_0000 + 32'(i), vecs[i].delay, vecs[i].sel, vecs[i].z,
                      vecs[i].off, vecs[i].tgt, vecs[i].jr, 1'b0, 1'b0, vecs[i].exp, lat);
        end
        check("retired_flow", retired, exp_retired);

        // Halt and resume together in ISSUE: halt wins
        run_instr(32'hA5A5_0001, 1, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                  1'b1, 1'b1, 32'h0C00_0000, lat);
        check("halted_after_halt", halted, 1);
        frozen_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = i[0];
            exec_done = ~i[0];
            @(negedge clock);
            if (pc !== 32'h0C00_0000 || halted !== 1'b1 || imem_req !== 1'b0)
                frozen_ok = 1'b0;
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        @(negedge clock);
        check("halt_frozen", frozen_ok, 1);
        check("retired_halted", retired, exp_retired);
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        check("halted_after_resume", halted, 0);
        run_instr(32'hA5A5_0002, 0, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                  1'b0, 1'b0, 32'h0C00_0001, lat);
        check("fetch_after_resume", lat, 1);

        // Fetch timeout: no ack at all
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("tmo_req_seen", imem_req, 1);
        repeat (14) @(negedge clock);
        check("tmo_not_early", fetch_err, 0);
        check("tmo_req_held", imem_req, 1);
        @(negedge clock);
        check("tmo_fetch_err", fetch_err, 1);
        check("tmo_req_dropped", imem_req, 0);
        check("tmo_halted", halted, 1);
        resume = 1'b1;
        repeat (3) @(negedge clock);
        resume = 1'b0;
        check("tmo_resume_ignored", halted, 1);
        check("tmo_err_sticky", fetch_err, 1);
        check("tmo_no_refetch", imem_req, 0);

        #2 reset = 1'b0;
        #1 check_reset_values("tmo_rst");
        exp_retired = 0;
        addr_q.push_back(32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        run_instr(32'h7777_0001, 0, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                  1'b0, 1'b0, 32'h1, lat);

        // Asynchronous reset while a request is outstanding
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("mid_req_seen", imem_req, 1);
        check("mid_retired_before", retired, exp_retired);
        #2 reset = 1'b0;
        #1 check_reset_values("mid_rst");
        exp_retired = 0;
        addr_q.push_back(32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        run_instr(32'h7777_0002, 0, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                  1'b0, 1'b0, 32'h1, lat);
        check("retired_after_reset", retired, exp_retired);

        repeat (3) @(negedge clock);
        check("addr_q_drained", addr_q.size(), 0);
        check("instr_q_drained", instr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
